// File: rtl/mmcm_drp_pkg.sv
// Shared definitions for the MMCM DRP reconfiguration sequencer.
//   - FSM state encodings (plain 4-bit constants)
//   - configuration-table entry layout: {addr[6:0], mask[15:0], data[15:0]}
//   - well-known MMCM DRP register addresses
//   - read-modify-write merge helper
package mmcm_drp_pkg;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 16;
    localparam int ENTRY_W  = 39;
    localparam int DATA_LSB = 0;
    localparam int MASK_LSB = 16;
    localparam int ADDR_LSB = 32;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_HOLD      = 4'd1;
    localparam state_t ST_RD_REQ    = 4'd2;
    localparam state_t ST_RD_WAIT   = 4'd3;
    localparam state_t ST_WR_REQ    = 4'd4;
    localparam state_t ST_WR_WAIT   = 4'd5;
    localparam state_t ST_RELEASE   = 4'd6;
    localparam state_t ST_LOCK_WAIT = 4'd7;
    localparam state_t ST_DONE      = 4'd8;
    localparam state_t ST_FAIL      = 4'd9;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] data;
    } drp_entry_t;

    // Common MMCM DRP register addresses used when building cfg_table.
    localparam logic [ADDR_W-1:0] DRP_CLKOUT0_REG1 = 7'h08;
    localparam logic [ADDR_W-1:0] DRP_CLKOUT0_REG2 = 7'h09;
    localparam logic [ADDR_W-1:0] DRP_CLKOUT1_REG1 = 7'h0A;
    localparam logic [ADDR_W-1:0] DRP_CLKOUT1_REG2 = 7'h0B;
    localparam logic [ADDR_W-1:0] DRP_CLKFB_REG1   = 7'h14;
    localparam logic [ADDR_W-1:0] DRP_CLKFB_REG2   = 7'h15;
    localparam logic [ADDR_W-1:0] DRP_DIVCLK_REG   = 7'h16;
    localparam logic [ADDR_W-1:0] DRP_LOCK_REG1    = 7'h18;
    localparam logic [ADDR_W-1:0] DRP_LOCK_REG2    = 7'h19;
    localparam logic [ADDR_W-1:0] DRP_LOCK_REG3    = 7'h1A;
    localparam logic [ADDR_W-1:0] DRP_POWER_REG    = 7'h28;
    localparam logic [ADDR_W-1:0] DRP_FILT_REG1    = 7'h4E;
    localparam logic [ADDR_W-1:0] DRP_FILT_REG2    = 7'h4F;

    // Mask bit 1 keeps the bit read back from the MMCM; mask bit 0 takes
    // the bit from the table data.
    function automatic logic [DATA_W-1:0] drp_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] mask,
        input logic [DATA_W-1:0] data
    );
        return (old_val & mask) | (data & ~mask);
    endfunction

endpackage

// File: rtl/mmcm_drp_reconfig_sync_2ff.sv
// Two-flop synchroniser, used for the MMCM LOCKED signal.
//   clk   : destination clock
//   rst_n : async active-low reset, output resets to 0
//   d     : asynchronous input
//   q     : synchronised output, 2 cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// MMCM DRP reconfiguration sequencer.
// On start: holds MMCM RST, read-modify-writes NUM_REGS DRP registers from
// cfg_table, releases RST and waits for LOCKED; reports done or error.
//   clk          : DRP clock (also MMCM DCLK)
//   rst_n        : async active-low reset
//   start        : single-cycle request, accepted only when idle
//   cfg_table    : entry k at [39k+38:39k] = {addr, mask, data}
//   drp_*        : MMCM DRP port (DADDR/DEN/DWE/DI/DO/DRDY)
//   mmcm_rst     : MMCM RST, active high
//   mmcm_locked  : MMCM LOCKED, asynchronous
//   busy/done/error : status (done is a pulse, error is sticky)
module mmcm_drp_reconfig
    import mmcm_drp_pkg::*;
#(
    parameter int NUM_REGS     = 4,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int RST_HOLD     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [NUM_REGS*ENTRY_W-1:0] cfg_table,
    output logic [ADDR_W-1:0]           drp_addr,
    output logic                        drp_en,
    output logic                        drp_we,
    output logic [DATA_W-1:0]           drp_di,
    input  logic [DATA_W-1:0]           drp_do,
    input  logic                        drp_rdy,
    output logic                        mmcm_rst,
    input  logic                        mmcm_locked,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TMR_MAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int HOLD_W  = $clog2(RST_HOLD + 1);

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [HOLD_W-1:0]  hold_reg;
    logic [TMR_W-1:0]   timer_reg;
    logic [DATA_W-1:0]  di_reg;
    logic               mmcm_rst_reg;
    logic               error_reg;
    logic               lock_s;

    drp_entry_t         entry_arr [NUM_REGS];
    drp_entry_t         cur_entry;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            assign entry_arr[gi] = drp_entry_t'(cfg_table[gi*ENTRY_W +: ENTRY_W]);
        end
    endgenerate

    assign cur_entry = entry_arr[idx_reg];

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mmcm_locked),
        .q     (lock_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            hold_reg     <= '0;
            timer_reg    <= '0;
            di_reg       <= '0;
            mmcm_rst_reg <= 1'b1;
            error_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg    <= ST_HOLD;
                        error_reg    <= 1'b0;
                        idx_reg      <= '0;
                        mmcm_rst_reg <= 1'b1;
                        hold_reg     <= HOLD_W'(RST_HOLD - 1);
                    end
                end
                ST_HOLD: begin
                    if (hold_reg == '0) begin
                        state_reg <= ST_RD_REQ;
                    end else begin
                        hold_reg <= hold_reg - 1'b1;
                    end
                end
                ST_RD_REQ: begin
                    timer_reg <= '0;
                    state_reg <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (drp_rdy) begin
                        di_reg    <= drp_merge(drp_do, cur_entry.mask, cur_entry.data);
                        state_reg <= ST_WR_REQ;
                    end else if (timer_reg == TMR_W'(DRDY_TIMEOUT - 1)) begin
                        state_reg <= ST_FAIL;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_WR_REQ: begin
                    timer_reg <= '0;
                    state_reg <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (drp_rdy) begin
                        if (idx_reg == IDX_W'(NUM_REGS - 1)) begin
                            state_reg <= ST_RELEASE;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= ST_RD_REQ;
                        end
                    end else if (timer_reg == TMR_W'(DRDY_TIMEOUT - 1)) begin
                        state_reg <= ST_FAIL;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    mmcm_rst_reg <= 1'b0;
                    timer_reg    <= '0;
                    state_reg    <= ST_LOCK_WAIT;
                end
                ST_LOCK_WAIT: begin
                    if (lock_s) begin
                        state_reg <= ST_DONE;
                    end else if (timer_reg == TMR_W'(LOCK_TIMEOUT - 1)) begin
                        state_reg <= ST_FAIL;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                ST_FAIL: begin
                    error_reg    <= 1'b1;
                    mmcm_rst_reg <= 1'b1;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register so an async reset
    // clears them immediately; the address is only driven during a strobe.
    assign drp_en   = (state_reg == ST_RD_REQ) || (state_reg == ST_WR_REQ);
    assign drp_we   = (state_reg == ST_WR_REQ);
    assign drp_addr = drp_en ? cur_entry.addr : '0;
    assign drp_di   = di_reg;
    assign mmcm_rst = mmcm_rst_reg;
    assign busy     = (state_reg != ST_IDLE) && (state_reg != ST_DONE) && (state_reg != ST_FAIL);
    assign done     = (state_reg == ST_DONE);
    assign error    = error_reg;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Scoreboard bench for mmcm_drp_reconfig with NUM_REGS=2. A DRP register
// model answers zero-wait, a lock model raises LOCKED 10 cycles after RST
// release. Expected writes and results are queued at stimulus time and
// popped by a monitor at each negedge.
module tb_mmcm_drp_reconfig;

    localparam int NR = 2;

    typedef struct {
        logic [6:0]  a;
        logic [15:0] d;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [NR*39-1:0] cfg_table;
    logic [6:0]      drp_addr;
    logic            drp_en;
    logic            drp_we;
    logic [15:0]     drp_di;
    logic [15:0]     drp_do;
    logic            drp_rdy;
    logic            mmcm_rst;
    logic            mmcm_locked;
    logic            busy;
    logic            done;
    logic            error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    wr_t exp_wr [$];
    int  exp_res [$];     // 0 = done, 1 = error
    int  en_cnt = 0;
    int  t_rel = 0, t_done = 0, t_err = 0, t_en = 0;

    // model controls
    logic        load_mem, lock_never, rdy_sp;
    logic [15:0] pat8, pat9;
    int          drop_read;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mmcm_drp_reconfig #(
        .NUM_REGS(NR), .DRDY_TIMEOUT(64), .LOCK_TIMEOUT(1024), .RST_HOLD(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_table(cfg_table),
        .drp_addr(drp_addr), .drp_en(drp_en), .drp_we(drp_we), .drp_di(drp_di),
        .drp_do(drp_do), .drp_rdy(drp_rdy), .mmcm_rst(mmcm_rst),
        .mmcm_locked(mmcm_locked), .busy(busy), .done(done), .error(error)
    );

    // DRP register model: answers every access on the following cycle,
    // except the read numbered drop_read (counted since the last load).
    logic [15:0] mem [0:127];
    logic        rdy_m = 1'b0;
    logic [15:0] do_m = '0;
    int          rd_cnt = 0;
    always @(posedge clk) begin
        rdy_m <= 1'b0;
        if (load_mem) begin
            mem[8]  <= pat8;
            mem[9]  <= pat9;
            rd_cnt  <= 0;
        end else if (drp_en) begin
            if (drp_we) begin
                mem[drp_addr] <= drp_di;
                rdy_m <= 1'b1;
            end else begin
                do_m   <= mem[drp_addr];
                rd_cnt <= rd_cnt + 1;
                if (rd_cnt + 1 != drop_read) rdy_m <= 1'b1;
            end
        end
    end
    assign drp_rdy = rdy_m | rdy_sp;
    assign drp_do  = do_m;

    // Lock model: LOCKED rises 10 cycles after RST falls.
    logic locked_m = 1'b0;
    int   lk_cnt = 0;
    always @(posedge clk) begin
        if (mmcm_rst) begin
            lk_cnt   <= 0;
            locked_m <= 1'b0;
        end else if (!lock_never) begin
            if (lk_cnt == 9) locked_m <= 1'b1;
            if (lk_cnt < 100) lk_cnt <= lk_cnt + 1;
        end
    end
    assign mmcm_locked = locked_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic pop_result(input int act);
        int req;
        chk("result_expected", (exp_res.size() != 0), 1);
        if (exp_res.size() != 0) begin
            req = exp_res.pop_front();
            chk("result_kind", act, req);
        end
        $display("cyc=%0d result %s", cyc, (act == 0) ? "done" : "error");
    endtask

    // Monitor
    initial begin : monitor
        logic rst_prev, err_prev;
        wr_t  e;
        rst_prev = 1'b1;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (drp_en) begin
                en_cnt++;
                t_en = cyc;
                chk("rst_held_during_drp", mmcm_rst, 1);
                if (drp_we) begin
                    chk("wr_expected", (exp_wr.size() != 0), 1);
                    if (exp_wr.size() != 0) begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", drp_addr, e.a);
                        chk("wr_data", drp_di, e.d);
                    end
                    $display("cyc=%0d write addr=0x%02h data=0x%04h", cyc, drp_addr, drp_di);
                end
            end
            if (!mmcm_rst && rst_prev) t_rel = cyc;
            rst_prev = mmcm_rst;
            if (done) begin
                t_done = cyc;
                chk("busy_at_done", busy, 0);
                pop_result(0);
            end
            if (error && !err_prev) begin
                t_err = cyc;
                pop_result(1);
            end
            err_prev = error;
        end
    end

    task automatic push_wr(input logic [6:0] a, input logic [15:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_wr.push_back(w);
    endtask

    task automatic set_pat(input logic [15:0] a, input logic [15:0] b);
        pat8 = a;
        pat9 = b;
        @(negedge clk) load_mem = 1'b1;
        @(negedge clk) load_mem = 1'b0;
    endtask

    task automatic do_start(output int ts);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        ts = cyc;
    endtask

    task automatic wait_res(input int budget);
        int n;
        n = 0;
        while (exp_res.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("result_in_time", exp_res.size(), 0);
        exp_res.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_drp_en"}, drp_en, 0);
        chk({tag, "_drp_we"}, drp_we, 0);
        chk({tag, "_drp_addr"}, drp_addr, 0);
        chk({tag, "_drp_di"}, drp_di, 0);
        chk({tag, "_mmcm_rst"}, mmcm_rst, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    initial begin : main
        int ts, en_base, n;
        rst_n = 1'b0; start = 1'b0; load_mem = 1'b0; lock_never = 1'b0;
        rdy_sp = 1'b0; pat8 = '0; pat9 = '0; drop_read = 0;
        cfg_table = {7'h09, 16'h00FF, 16'hAB00, 7'h08, 16'hF000, 16'h0145};
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_mmcm_rst", mmcm_rst, 1);

        // T1: basic RMW, zero-wait DRP, lock after 10 cycles
        set_pat(16'h1234, 16'h5678);
        push_wr(7'h08, 16'h1145);
        push_wr(7'h09, 16'hAB78);
        exp_res.push_back(0);
        en_base = en_cnt;
        do_start(ts);
        chk("t1_busy", busy, 1);
        wait_res(200);
        chk("t1_latency", t_done - ts, 26);
        chk("t1_en_pulses", en_cnt - en_base, 4);
        chk("t1_error", error, 0);
        repeat (3) @(negedge clk);
        chk("t1_mmcm_rst_low", mmcm_rst, 0);
        chk("t1_busy_idle", busy, 0);

        // T2: different data pattern, done timing relative to RST release
        set_pat(16'hFFFF, 16'h0000);
        push_wr(7'h08, 16'hF145);
        push_wr(7'h09, 16'hAB00);
        exp_res.push_back(0);
        do_start(ts);
        wait_res(200);
        chk_rng("t2_release_to_done", t_done - t_rel, 12, 13);
        chk("t2_error", error, 0);
        repeat (5) @(negedge clk);
        chk("t2_mmcm_rst_stays_low", mmcm_rst, 0);

        // T3: LOCKED never rises
        lock_never = 1'b1;
        set_pat(16'h0000, 16'hFFFF);
        push_wr(7'h08, 16'h0145);
        push_wr(7'h09, 16'hABFF);
        exp_res.push_back(1);
        do_start(ts);
        wait_res(1300);
        chk_rng("t3_release_to_error", t_err - t_rel, 1024, 1026);
        chk("t3_mmcm_rst_high", mmcm_rst, 1);
        chk("t3_busy", busy, 0);
        chk("t3_error", error, 1);
        lock_never = 1'b0;

        // T4: second read never answered; start also clears the old error
        drop_read = 2;
        set_pat(16'h1234, 16'h5678);
        push_wr(7'h08, 16'h1145);
        exp_res.push_back(1);
        en_base = en_cnt;
        do_start(ts);
        chk("t4_error_cleared", error, 0);
        wait_res(300);
        chk_rng("t4_en_to_error", t_err - t_en, 64, 67);
        repeat (20) @(negedge clk);
        chk("t4_en_pulses", en_cnt - en_base, 3);
        chk("t4_error_sticky", error, 1);
        chk("t4_mmcm_rst_high", mmcm_rst, 1);
        drop_read = 0;

        // T5: start pulses while busy and a stray drp_rdy during HOLD
        set_pat(16'hAAAA, 16'h5555);
        push_wr(7'h08, 16'hA145);
        push_wr(7'h09, 16'hAB55);
        exp_res.push_back(0);
        en_base = en_cnt;
        do_start(ts);
        rdy_sp = 1'b1;
        @(negedge clk) rdy_sp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        wait_res(200);
        chk("t5_latency", t_done - ts, 26);
        chk("t5_en_pulses", en_cnt - en_base, 4);
        chk("t5_writes_drained", exp_wr.size(), 0);

        // T6: async reset during WR_WAIT, then a clean run
        set_pat(16'h1234, 16'h5678);
        push_wr(7'h08, 16'h1145);
        push_wr(7'h09, 16'hAB78);
        exp_res.push_back(0);
        do_start(ts);
        n = 0;
        while (!drp_we && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_saw_write", drp_we, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("t6_async");
        chk("t6_pending_writes", exp_wr.size(), 1);
        exp_wr.delete();
        exp_res.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_wr(7'h08, 16'h1145);
        push_wr(7'h09, 16'hAB78);
        exp_res.push_back(0);
        do_start(ts);
        wait_res(200);
        chk("t6_latency", t_done - ts, 26);
        repeat (2) @(negedge clk);
        chk("t6_mmcm_rst_low", mmcm_rst, 0);
        chk("final_writes_drained", exp_wr.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmcm_drp_reconfig.md
Name: mmcm_drp_reconfig

Overview:
- Sequencer directly upstream of the MMCM replacement. It drives that block's DRP port (DADDR/DEN/DWE/DI, consuming DO/DRDY) and its RST input.
- On a request it holds the MMCM in reset, then does a read-modify-write of NUM_REGS DRP registers taken from a configuration table.
- It then releases reset and waits for LOCKED, reporting done or error.
- Runs on the DRP clock (clk, which also feeds the MMCM DCLK).

Parameters:
NUM_REGS, 4, number of table entries (1..16)
DRDY_TIMEOUT, 64, clk cycles allowed per DRP access before error
LOCK_TIMEOUT, 1024, clk cycles allowed after RST release for LOCKED
RST_HOLD, 4, clk cycles MMCM RST is held before first DRP access

Ports:
clk  in  1  DRP/sequencer clock; also drives MMCM DCLK
rst_n  in  1  async active-low reset
start  in  1  single-cycle request; ignored unless busy=0
cfg_table  in  NUM_REGS*39  entry k at [39k+38:39k] = {addr[6:0], mask[15:0], data[15:0]}
drp_addr  out  7  to MMCM DADDR
drp_en  out  1  to MMCM DEN, single-cycle strobe
drp_we  out  1  to MMCM DWE
drp_di  out  16  to MMCM DI
drp_do  in  16  from MMCM DO
drp_rdy  in  1  from MMCM DRDY
mmcm_rst  out  1  to MMCM RST (active high)
mmcm_locked  in  1  from MMCM LOCKED (asynchronous to clk)
busy  out  1  sequence in progress
done  out  1  one-cycle pulse, success
error  out  1  sticky until next accepted start; timeout occurred

Behaviour:
- The interface is fixed: one clock; reset is asynchronous and active-low.
- Reset values: drp_en=0, drp_we=0, drp_addr=0, drp_di=0, mmcm_rst=1, busy=0, done=0, error=0. The state machine resets to IDLE.
- In IDLE after reset, mmcm_rst stays 1 until the first sequence completes. An error also leaves it at 1.
- mmcm_locked passes through a 2-flop synchroniser (lock_s). This gives 2 cycles of latency.
- FSM states and transitions:
  - IDLE: start=1 -> HOLD. Set busy=1, error=0, idx=0, mmcm_rst=1, and load the hold counter with RST_HOLD-1.
  - HOLD: count down. At 0 -> RD_REQ.
  - RD_REQ: drive drp_en=1, drp_we=0, drp_addr=entry[idx].addr for exactly 1 cycle -> RD_WAIT.
  - RD_WAIT: on drp_rdy=1, capture new = (drp_do & mask) | (data & ~mask) -> WR_REQ. Mask bit 1 keeps the old bit.
  - WR_REQ: drive drp_en=1, drp_we=1, same addr, drp_di=new for 1 cycle -> WR_WAIT.
  - WR_WAIT: on drp_rdy=1, if idx==NUM_REGS-1 -> RELEASE, else idx+1 -> RD_REQ.
  - RELEASE: set mmcm_rst=0, clear the timer -> LOCK_WAIT.
  - LOCK_WAIT: lock_s=1 -> DONE. Timer reaching LOCK_TIMEOUT-1 -> FAIL.
  - DONE: done=1 for 1 cycle, busy=0 -> IDLE. mmcm_rst stays 0.
  - FAIL: error=1, mmcm_rst=1, busy=0 -> IDLE.
- DRDY timeout: the timer clears on each RD_REQ/WR_REQ. If drp_rdy is absent for DRDY_TIMEOUT cycles in RD_WAIT/WR_WAIT -> FAIL.
- drp_rdy arriving outside a WAIT state is ignored. drp_en is never asserted again until the previous access has returned drp_rdy or timed out.
- start while busy=1 is ignored, with no effect on the sequence.
- start on the same cycle as DONE/FAIL is ignored; it is accepted only in IDLE.
- Mid-sequence rst_n assertion: everything returns to reset values immediately, including mmcm_rst=1. The partial DRP writes are not undone.
- Widths:
  - idx is clog2(NUM_REGS), minimum 1 bit.
  - The timer is wide enough for max(DRDY_TIMEOUT, LOCK_TIMEOUT).
  - The hold counter is clog2(RST_HOLD+1) bits.
- Total latency with a zero-wait DRP (drp_rdy the cycle after drp_en) and lock at L cycles after release: 1 + RST_HOLD + 4*NUM_REGS + 1 + L + 2 cycles from start to done.

Decomposition:
- Shared package mmcm_drp_pkg:
  - FSM state enum (IDLE, HOLD, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RELEASE, LOCK_WAIT, DONE, FAIL).
  - Entry field widths and offsets (ADDR_W=7, DATA_W=16, ENTRY_W=39).
  - Well-known MMCM DRP addresses as constants.
- One sub-module, sync_2ff: the 2-flop synchroniser for mmcm_locked, with async active-low reset to 0.

Test Plan:
- Zero-wait DRP model, NUM_REGS=2: entry0={7'h08,16'hF000,16'h0145}, model reg 0x08 holds 16'h1234, start -> write of 16'h1145 to 0x08; drp_en pulses=4; mmcm_rst=1 throughout; done after lock; busy deasserts with done.
- Lock model: mmcm_locked rises 10 cycles after mmcm_rst falls -> done pulses exactly 12 or 13 cycles after RELEASE; error=0; mmcm_rst stays 0.
- mmcm_locked held 0 -> error=1 at LOCK_TIMEOUT cycles after release; mmcm_rst returns to 1; next start clears error.
- DRP model never returns drp_rdy on the 2nd read -> FAIL after 64 cycles; no further drp_en; error=1.
- start pulsed repeatedly while busy, plus a spurious drp_rdy in HOLD -> sequence unchanged; exactly 4*NUM_REGS drp_en pulses.
- rst_n driven low during WR_WAIT -> all outputs at reset values asynchronously, mmcm_rst=1; a fresh start after release runs to completion.
